// File: rtl/psum_collector.sv
// Deskews south-edge partial sums from an N-column systolic array into aligned
// rows and buffers them in a credit-managed output FIFO.
module psum_collector #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] psum_in,
  input  logic           compute,
  input  logic           row_start,
  input  logic           flush,
  input  logic           clr_ovf,
  output logic [N*W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           can_accept,
  output logic           overflow
);
  localparam int unsigned RW   = N * W;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(DEPTH + N) + 1;

  logic [N-2:0]    r_tag;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CNTW-1:0] r_count;
  logic [RW-1:0]   r_mem [DEPTH];
  logic [RW-1:0]   r_out_data;
  logic            r_out_valid;
  logic            r_can_accept;
  logic            r_overflow;

  logic [RW-1:0]   w_row;
  logic            w_accept;
  logic            w_drop;
  logic            w_push;
  logic            w_full_hit;
  logic            w_push_ok;
  logic            w_pop;
  logic [N-2:0]    w_tag_nxt;
  logic [AW-1:0]   w_wptr_nxt;
  logic [AW-1:0]   w_rptr_nxt;
  logic [CNTW-1:0] w_count_nxt;
  logic [RW-1:0]   w_out_data_nxt;
  logic [CW-1:0]   w_inflight_nxt;
  logic            w_can_accept_nxt;
  logic            w_overflow_nxt;

  // Column j waits N-1-j compute cycles so all columns of a row line up.
  genvar j;
  generate
    for (j = 0; j < N - 1; j++) begin : g_col
      localparam int unsigned S = N - 1 - j;
      logic [W-1:0] r_d [S];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < S; k++) r_d[k] <= '0;
        end else if (flush) begin
          for (int k = 0; k < S; k++) r_d[k] <= '0;
        end else if (compute) begin
          r_d[0] <= psum_in[j*W +: W];
          for (int k = 1; k < S; k++) r_d[k] <= r_d[k-1];
        end
      end

      assign w_row[j*W +: W] = r_d[S-1];
    end
  endgenerate

  assign w_row[(N-1)*W +: W] = psum_in[(N-1)*W +: W];

  always_comb begin
    w_accept   = row_start & compute & r_can_accept & ~flush;
    w_drop     = row_start & compute & ~r_can_accept;
    w_push     = compute & r_tag[N-2] & ~flush;
    w_full_hit = w_push & (r_count == CNTW'(DEPTH));
    w_push_ok  = w_push & ~w_full_hit;
    w_pop      = r_out_valid & out_ready & ~flush;

    w_tag_nxt = r_tag;
    if (compute) begin
      w_tag_nxt[0] = w_accept;
      for (int k = 1; k < N - 1; k++) w_tag_nxt[k] = r_tag[k-1];
    end
    if (flush) w_tag_nxt = '0;

    w_wptr_nxt     = r_wptr;
    w_rptr_nxt     = r_rptr;
    w_count_nxt    = r_count;
    w_out_data_nxt = r_out_data;
    if (w_push_ok) w_wptr_nxt = r_wptr + AW'(1);
    if (w_pop)     w_rptr_nxt = r_rptr + AW'(1);
    if (w_push_ok && !w_pop)      w_count_nxt = r_count + CNTW'(1);
    else if (!w_push_ok && w_pop) w_count_nxt = r_count - CNTW'(1);

    // Head register follows the next entry on a pop, or a row landing in an empty queue.
    if (w_pop) begin
      if (r_count > CNTW'(1))  w_out_data_nxt = r_mem[r_rptr + AW'(1)];
      else if (w_push_ok)      w_out_data_nxt = w_row;
    end else if (w_push_ok && r_count == '0) begin
      w_out_data_nxt = w_row;
    end

    if (flush) begin
      w_wptr_nxt  = '0;
      w_rptr_nxt  = '0;
      w_count_nxt = '0;
    end

    w_inflight_nxt = '0;
    for (int k = 0; k < N - 1; k++) w_inflight_nxt = w_inflight_nxt + CW'(w_tag_nxt[k]);
    w_can_accept_nxt = (CW'(w_count_nxt) + w_inflight_nxt) < CW'(DEPTH);

    w_overflow_nxt = w_drop | w_full_hit | (r_overflow & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag        <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_can_accept <= 1'b1;
      r_overflow   <= 1'b0;
    end else begin
      r_tag        <= w_tag_nxt;
      r_wptr       <= w_wptr_nxt;
      r_rptr       <= w_rptr_nxt;
      r_count      <= w_count_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_valid  <= (w_count_nxt != '0);
      r_can_accept <= w_can_accept_nxt;
      r_overflow   <= w_overflow_nxt;
    end
  end

  // Row storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= w_row;
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign can_accept = r_can_accept;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_psum_collector.sv
// Self-checking bench for psum_collector: queue-based row model plus directed vectors.
module tb_psum_collector;
  localparam int unsigned N     = 4;
  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = N * W;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic [RW-1:0] psum_in   = '0;
  logic          compute   = 1'b0;
  logic          row_start = 1'b0;
  logic          flush     = 1'b0;
  logic          clr_ovf   = 1'b0;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          can_accept;
  logic          overflow;

  int n_total = 0;
  int n_bad   = 0;
  int cc      = 0;
  bit cmp_en  = 1'b0;

  // Model: rows in flight carry how many columns they have captured so far.
  logic [RW-1:0] m_fifo [$];
  int            p_age  [$];
  logic [RW-1:0] p_row  [$];
  bit            m_ovf = 1'b0;

  psum_collector #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .psum_in(psum_in), .compute(compute),
    .row_start(row_start), .flush(flush), .clr_ovf(clr_ovf),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .can_accept(can_accept), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_b(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_d(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] row4(input logic [W-1:0] c3, input logic [W-1:0] c2,
                                         input logic [W-1:0] c1, input logic [W-1:0] c0);
    return {c3, c2, c1, c0};
  endfunction

  // Column j at compute cycle cc carries the element of the row started at cc-j.
  function automatic logic [RW-1:0] pat(input int c);
    logic [RW-1:0] v;
    v = '0;
    for (int k = 0; k < int'(N); k++) v[k*W +: W] = {8'(c - k), 8'(k), 16'hC0DE};
    return v;
  endfunction

  function automatic logic [RW-1:0] rowval(input int s);
    logic [RW-1:0] v;
    v = '0;
    for (int k = 0; k < int'(N); k++) v[k*W +: W] = {8'(s), 8'(k), 16'hC0DE};
    return v;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    p_age.delete();
    p_row.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_step();
    int            fcnt;
    int            infl;
    bit            ca;
    bit            drop;
    bit            push_full;
    bit            have_push;
    logic [RW-1:0] t;
    logic [RW-1:0] prow;
    fcnt      = m_fifo.size();
    infl      = p_age.size();
    ca        = (fcnt + infl) < int'(DEPTH);
    drop      = row_start && compute && !ca;
    push_full = 1'b0;
    have_push = 1'b0;
    prow      = '0;
    if (flush) begin
      m_fifo.delete();
      p_age.delete();
      p_row.delete();
    end else begin
      if (compute) begin
        for (int i = 0; i < p_age.size(); i++) begin
          t = p_row[i];
          t[p_age[i]*W +: W] = psum_in[p_age[i]*W +: W];
          p_row[i] = t;
          p_age[i] = p_age[i] + 1;
        end
        if (p_age.size() > 0 && p_age[0] == int'(N)) begin
          have_push = 1'b1;
          prow = p_row[0];
          void'(p_age.pop_front());
          void'(p_row.pop_front());
        end
        if (row_start && ca) begin
          t = '0;
          t[W-1:0] = psum_in[W-1:0];
          p_age.push_back(1);
          p_row.push_back(t);
        end
      end
      if (fcnt > 0 && out_ready) void'(m_fifo.pop_front());
      if (have_push) begin
        if (fcnt == int'(DEPTH)) push_full = 1'b1;
        else m_fifo.push_back(prow);
      end
    end
    m_ovf = drop || push_full || (m_ovf && !clr_ovf);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check_b("cyc_out_valid", out_valid, m_fifo.size() > 0);
        if (m_fifo.size() > 0) check_d("cyc_out_data", out_data, m_fifo[0]);
        check_b("cyc_can_accept", can_accept, (m_fifo.size() + p_age.size()) < int'(DEPTH));
        check_b("cyc_overflow", overflow, m_ovf);
      end
    end
  end

  task automatic step(input logic c, input logic rs, input logic rdy, input logic [RW-1:0] d);
    compute   = c;
    row_start = rs;
    out_ready = rdy;
    psum_in   = d;
    if (c) cc++;
    @(negedge clk);
  endtask

  task automatic step_p(input logic c, input logic rs, input logic rdy);
    step(c, rs, rdy, pat(cc));
  endtask

  int            s0;
  int            issued;
  logic          rs_q;
  logic [RW-1:0] got    [$];
  int            starts [$];

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check_b("rst_out_valid", out_valid, 1'b0);
    check_b("rst_can_accept", can_accept, 1'b1);
    check_b("rst_overflow", overflow, 1'b0);
    check_d("rst_out_data", out_data, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Single float row, compute held high.
    step(1, 1, 0, row4(32'h0, 32'h0, 32'h0, 32'h3F800000));
    step(1, 0, 0, row4(32'h0, 32'h0, 32'h40000000, 32'h0));
    step(1, 0, 0, row4(32'h0, 32'h40400000, 32'h0, 32'h0));
    check_b("single_not_yet", out_valid, 1'b0);
    step(1, 0, 0, row4(32'h40800000, 32'h0, 32'h0, 32'h0));
    check_b("single_valid", out_valid, 1'b1);
    check_d("single_data", out_data, 128'h40800000_40400000_40000000_3F800000);
    step(0, 0, 1, '0);
    check_b("single_popped", out_valid, 1'b0);

    // Same row with a two-cycle stall after e1.
    step(1, 1, 0, row4(32'h0, 32'h0, 32'h0, 32'h3F800000));
    step(1, 0, 0, row4(32'h0, 32'h0, 32'h40000000, 32'h0));
    step(0, 0, 0, '1);
    step(0, 0, 0, '1);
    step(1, 0, 0, row4(32'h0, 32'h40400000, 32'h0, 32'h0));
    check_b("stall_not_yet", out_valid, 1'b0);
    step(1, 0, 0, row4(32'h40800000, 32'h0, 32'h0, 32'h0));
    check_b("stall_valid", out_valid, 1'b1);
    check_d("stall_data", out_data, 128'h40800000_40400000_40000000_3F800000);
    step(0, 0, 1, '0);

    // Backpressure: four rows fill the credit, a fifth is dropped.
    s0 = cc;
    for (int k = 0; k < 4; k++) step_p(1, 1, 0);
    check_b("credit_exhausted", can_accept, 1'b0);
    step_p(1, 1, 0);
    check_b("drop_sets_ovf", overflow, 1'b1);
    clr_ovf = 1'b1;
    step_p(1, 1, 0);
    clr_ovf = 1'b0;
    check_b("drop_beats_clr", overflow, 1'b1);
    step_p(1, 0, 0);
    check_b("bp_full_valid", out_valid, 1'b1);
    check_b("bp_full_credit", can_accept, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check_d("bp_head_order", out_data, rowval(s0 + k));
      step(0, 0, 1, '0);
    end
    check_b("bp_drained", out_valid, 1'b0);
    clr_ovf = 1'b1;
    step(0, 0, 0, '0);
    clr_ovf = 1'b0;
    check_b("clr_ovf", overflow, 1'b0);

    // Push and pop on the same edge with two rows buffered.
    s0 = cc;
    for (int k = 0; k < 3; k++) step_p(1, 1, 0);
    step_p(1, 0, 0);
    step_p(1, 0, 0);
    step_p(1, 0, 1);
    check_d("pushpop_head", out_data, rowval(s0 + 1));
    check_b("pushpop_credit", can_accept, 1'b1);
    step(0, 0, 1, '0);
    check_d("pushpop_second", out_data, rowval(s0 + 2));
    step(0, 0, 1, '0);
    check_b("pushpop_empty", out_valid, 1'b0);

    // Ten rows streamed across the pointer wrap.
    issued = 0;
    for (int t = 0; t < 80 && (issued < 10 || got.size() < 10); t++) begin
      if (out_valid) got.push_back(out_data);
      rs_q = (issued < 10) && can_accept;
      if (rs_q) begin
        starts.push_back(cc);
        issued++;
      end
      step_p(1, rs_q, 1);
    end
    check_b("stream_count", got.size() == 10, 1'b1);
    for (int k = 0; k < got.size() && k < starts.size(); k++)
      check_d("stream_row", got[k], rowval(starts[k]));

    // Reset mid-row discards it.
    step_p(1, 1, 1);
    step_p(1, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check_b("midrst_out_valid", out_valid, 1'b0);
    check_b("midrst_can_accept", can_accept, 1'b1);
    check_b("midrst_overflow", overflow, 1'b0);
    check_d("midrst_out_data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step_p(1, 0, 1);
    check_b("midrst_no_stale", out_valid, 1'b0);

    // First row after reset keeps the normal latency.
    s0 = cc;
    step_p(1, 1, 0);
    step_p(1, 0, 0);
    step_p(1, 0, 0);
    check_b("postrst_not_yet", out_valid, 1'b0);
    step_p(1, 0, 0);
    check_b("postrst_valid", out_valid, 1'b1);
    check_d("postrst_data", out_data, rowval(s0));
    step(0, 0, 1, '0);

    // Flush with two rows buffered and one in flight.
    for (int k = 0; k < 3; k++) step_p(1, 1, 0);
    step_p(1, 0, 0);
    step_p(1, 0, 0);
    check_b("preflush_valid", out_valid, 1'b1);
    flush = 1'b1;
    step_p(1, 1, 1);
    flush = 1'b0;
    check_b("flush_out_valid", out_valid, 1'b0);
    check_b("flush_can_accept", can_accept, 1'b1);
    for (int k = 0; k < 6; k++) step_p(1, 0, 1);
    check_b("flush_no_stale", out_valid, 1'b0);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
